// File: rtl/expression_response_unpacker.sv
// expression_response_unpacker
// Buffers packed 90-bit expression result words {y0..y17} in a small FIFO and
// streams them out one field per beat, widened to OUT_W (sign-extended for
// signed slots, zero-extended otherwise) and tagged with the field index.
// Field i is 4+(i mod 3) bits wide and is signed when (i mod 6) >= 3.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; empties FIFO and rewinds the field index
//   in_valid   in_y holds a word
//   in_ready   a word can be accepted (FIFO not full)
//   in_y       packed word, y0 at the MSB
//   out_valid  out_data/out_idx/out_signed/out_last are valid
//   out_ready  consumer accepts the current field
//   out_data   extended field value
//   out_idx    field index 0..17
//   out_signed field slot is signed
//   out_last   current field is index 17
module expression_response_unpacker #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_signed,
  output logic             out_last
);

  localparam int unsigned WORD_W = 90;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned FMAX_W = 6;
  localparam int unsigned LSB_W  = 7;
  localparam int unsigned FW_W   = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 5'd17;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic [0:0]        w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [PW-1:0]     w_wr_ptr_nxt;
  logic [PW-1:0]     w_rd_ptr_nxt;
  logic              w_full;
  logic              w_push;
  logic              w_beat;
  logic              w_pop;
  logic [WORD_W-1:0] w_head;
  logic [LSB_W-1:0]  w_lsb;
  logic [FW_W-1:0]   w_fw;
  logic              w_fsigned;
  logic [FMAX_W-1:0] w_raw;
  logic              w_sbit;
  logic [OUT_W-1:0]  w_ext;

  // FIFO status: full when only the wrap bits differ
  assign w_full = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push = in_valid && !w_full;
  assign w_beat = (r_state == S_STREAM) && out_ready;
  assign w_pop  = w_beat && (r_idx == LAST_IDX);

  // Next-state / pointer / index update
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_idx_nxt    = r_idx;
    w_state_nxt  = r_state;
    if (w_push) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    if (w_beat) w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    w_state_nxt = (w_wr_ptr_nxt != w_rd_ptr_nxt) ? S_STREAM : S_IDLE;
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Word storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_y;
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  // LSB position of each field inside the packed word
  always_comb begin
    w_lsb = '0;
    case (r_idx)
      5'd0:    w_lsb = 7'd86;
      5'd1:    w_lsb = 7'd81;
      5'd2:    w_lsb = 7'd75;
      5'd3:    w_lsb = 7'd71;
      5'd4:    w_lsb = 7'd66;
      5'd5:    w_lsb = 7'd60;
      5'd6:    w_lsb = 7'd56;
      5'd7:    w_lsb = 7'd51;
      5'd8:    w_lsb = 7'd45;
      5'd9:    w_lsb = 7'd41;
      5'd10:   w_lsb = 7'd36;
      5'd11:   w_lsb = 7'd30;
      5'd12:   w_lsb = 7'd26;
      5'd13:   w_lsb = 7'd21;
      5'd14:   w_lsb = 7'd15;
      5'd15:   w_lsb = 7'd11;
      5'd16:   w_lsb = 7'd6;
      default: w_lsb = 7'd0;
    endcase
  end

  assign w_fw      = FW_W'(5'd4 + (r_idx % 5'd3));
  assign w_fsigned = (r_idx % 5'd6) >= 5'd3;
  assign w_raw     = FMAX_W'(w_head >> w_lsb);
  assign w_sbit    = w_fsigned && w_raw[w_fw - FW_W'(1)];

  // Widen: copy the field bits, fill above with the sign bit or zero
  always_comb begin
    w_ext = '0;
    for (int unsigned b = 0; b < OUT_W; b++) begin
      if (b < 32'(w_fw)) w_ext[b] = w_raw[b];
      else               w_ext[b] = w_sbit;
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = (r_state == S_STREAM);
  assign out_data   = out_valid ? w_ext : '0;
  assign out_idx    = r_idx;
  assign out_signed = w_fsigned;
  assign out_last   = (r_idx == LAST_IDX);

endmodule

// File: tb/tb_expression_response_unpacker.sv
// Testbench for expression_response_unpacker: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_expression_response_unpacker;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned OUT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [89:0]      in_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_signed;
  logic             out_last;

  expression_response_unpacker #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_signed(out_signed), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;
  logic [89:0] q[$];
  int e_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field i of a word: walk the field widths from the MSB, then extend
  function automatic logic [OUT_W-1:0] ref_field(input logic [89:0] word, input int i);
    int msb = 89;
    int w;
    int v;
    logic [89:0] s;
    for (int j = 0; j < i; j++) msb -= 4 + (j % 3);
    w = 4 + (i % 3);
    s = word >> (msb - w + 1);
    v = int'(s[5:0]) & ((1 << w) - 1);
    if ((i % 6) >= 3 && v >= (1 << (w - 1))) v -= (1 << w);
    return OUT_W'(v);
  endfunction

  function automatic logic [89:0] rand_word();
    return 90'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One clock cycle, entered and left at a falling edge
  task automatic cycle(input logic iv, input logic [89:0] iy, input logic ordy);
    logic fire_in;
    logic fire_out;
    in_valid  = iv;
    in_y      = iy;
    out_ready = ordy;
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("idx", 32'(out_idx), 32'(e_idx));
      check("data", 32'(out_data), 32'(ref_field(q[0], e_idx)));
      check("signed", 32'(out_signed), 32'((e_idx % 6) >= 3));
      check("last", 32'(out_last), 32'(e_idx == 17));
    end
    fire_in  = iv && in_ready;
    fire_out = out_valid && ordy;
    @(posedge clk);
    if (fire_out && q.size() != 0) begin
      n_beats++;
      if (e_idx == 17) begin
        e_idx = 0;
        void'(q.pop_front());
      end else begin
        e_idx++;
      end
    end
    if (fire_in) q.push_back(iy);
    @(negedge clk);
  endtask

  logic [7:0]  ones_exp [6];
  logic [89:0] wa, wb, wc, w2;
  logic [7:0]  d0;
  int first_v, last_v, cnt_v, pushed, budget, beats0;
  logic iv;

  initial begin
    ones_exp = '{8'h0F, 8'h1F, 8'h3F, 8'hFF, 8'hFF, 8'hFF};
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_signed", 32'(out_signed), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-ones word: latency and extension pattern
    cycle(1'b1, {90{1'b1}}, 1'b1);
    check("ones_first_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 18; k++) begin
      check("ones_idx", 32'(out_idx), 32'(k));
      check("ones_data", 32'(out_data), 32'(ones_exp[k % 6]));
      cycle(1'b0, '0, 1'b1);
    end
    check("ones_drained", 32'(out_valid), 32'd0);

    // Field 4 = 10000, field 13 = 01111, all else zero
    w2 = (90'd1 << 70) | (90'hF << 21);
    cycle(1'b1, w2, 1'b1);
    for (int k = 0; k < 18; k++) begin
      check("sparse_data", 32'(out_data),
            (k == 4) ? 32'hF0 : (k == 13) ? 32'h0F : 32'h00);
      cycle(1'b0, '0, 1'b1);
    end

    // Backpressure: fill the FIFO, hold off a third word
    wa = rand_word(); wb = rand_word(); wc = rand_word();
    cycle(1'b1, wa, 1'b0);
    cycle(1'b1, wb, 1'b0);
    d0 = out_data;
    for (int k = 0; k < 4; k++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data_stable", 32'(out_data), 32'(d0));
      check("bp_idx_stable", 32'(out_idx), 32'd0);
      cycle(1'b1, wc, 1'b0);
    end
    for (int k = 0; k < 18; k++) cycle(1'b1, wc, 1'b1);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    cycle(1'b1, wc, 1'b1);
    for (int k = 0; k < 40; k++) cycle(1'b0, '0, 1'b1);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Back-to-back words: 36 contiguous valid beats
    first_v = -1; last_v = -1; cnt_v = 0;
    wa = rand_word(); wb = rand_word();
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin
        cnt_v++;
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      cycle(n < 2, (n == 0) ? wa : wb, 1'b1);
    end
    check("b2b_count", 32'(cnt_v), 32'd36);
    check("b2b_span", 32'(last_v - first_v), 32'd35);

    // Reset mid-stream at idx 9 with a second word queued
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b1, rand_word(), 1'b1);
    for (int k = 0; k < 20 && e_idx != 9; k++) cycle(1'b0, '0, 1'b1);
    check("pre_rst_idx", 32'(out_idx), 32'd9);
    check("pre_rst_queued", 32'(q.size()), 32'd2);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    e_idx = 0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    cycle(1'b1, rand_word(), 1'b1);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_idx0", 32'(out_idx), 32'd0);
    for (int k = 0; k < 20; k++) cycle(1'b0, '0, 1'b1);

    // Randomized traffic, 100 words
    pushed = 0; budget = 0; beats0 = n_beats;
    while ((pushed < 100 || q.size() != 0) && budget < 20000) begin
      iv = (pushed < 100) && ($urandom_range(0, 1) == 1);
      if (iv && in_ready) pushed++;
      cycle(iv, rand_word(), $urandom_range(0, 3) != 0);
      budget++;
    end
    check("rand_pushed", 32'(pushed), 32'd100);
    check("rand_drained", 32'(q.size()), 32'd0);
    check("rand_beats", 32'(n_beats - beats0), 32'd1800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
